// File: rtl/dram_sniffer_pkg.sv
// rtl/dram_sniffer_pkg.sv - shared widths, FSM state codes and tag codes for dram_sniffer_arb
package dram_sniffer_pkg;

  localparam int DATA_W = 144;
  localparam int BE_W   = 18;
  localparam int ADDR_W = 32;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_APP_CMD = 3'd1;
  localparam logic [2:0] ST_APP_WR2 = 3'd2;
  localparam logic [2:0] ST_CPU_CMD = 3'd3;
  localparam logic [2:0] ST_CPU_WR2 = 3'd4;

  localparam logic TAG_APP = 1'b0;
  localparam logic TAG_CPU = 1'b1;

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
  } cmd_t;

endpackage

// File: rtl/dram_sniffer_tag_fifo.sv
// rtl/dram_sniffer_tag_fifo.sv - 1-bit tag FIFO recording which port owns each outstanding read
module dram_sniffer_tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/dram_sniffer_arb.sv
// rtl/dram_sniffer_arb.sv - app-priority two-port DRAM command arbiter with in-order read return
// Optional DRAM_SNIFFER_ARB_STATS_EN adds command and stall counters.
module dram_sniffer_arb
  import dram_sniffer_pkg::*;
#(
  parameter int TAG_DEPTH    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              dram_clk,
  input  logic              dram_rst,
  input  logic              app_cmd_en,
  input  logic              app_cmd_rnw,
  input  logic [ADDR_W-1:0] app_address,
  input  logic [DATA_W-1:0] app_wr_data,
  input  logic [BE_W-1:0]   app_wr_be,
  output logic              app_ack,
  output logic [DATA_W-1:0] app_rd_data,
  output logic              app_rd_dvld,
  input  logic              cpu_cmd_en,
  input  logic              cpu_cmd_rnw,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic [BE_W-1:0]   cpu_wr_be,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rd_dvld,
  output logic              dram_cmd_en,
  output logic              dram_cmd_rnw,
  output logic [ADDR_W-1:0] dram_address,
  output logic [DATA_W-1:0] dram_wr_data,
  output logic [BE_W-1:0]   dram_wr_be,
  input  logic              dram_ack,
  input  logic [DATA_W-1:0] dram_rd_data,
  input  logic              dram_rd_dvld,
  output logic              rd_orphan
`ifdef DRAM_SNIFFER_ARB_STATS_EN
  ,
  output logic [31:0]       stat_app_cmds,
  output logic [31:0]       stat_cpu_cmds,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          beat_q, beat_d;
  logic          orphan_q, orphan_d;

  cmd_t app_cmd, cpu_cmd, sel_cmd;
  logic sel_is_cpu, sel_en, in_cmd, in_wr2, starved;
  logic tag_push, tag_pop, tag_in, tag_head, tag_full, tag_empty, rd_route;

  assign app_cmd = {app_cmd_rnw, app_address, app_wr_data, app_wr_be};
  assign cpu_cmd = {cpu_cmd_rnw, cpu_address, cpu_wr_data, cpu_wr_be};

  assign sel_is_cpu = (state_q == ST_CPU_CMD) || (state_q == ST_CPU_WR2);
  assign in_cmd     = (state_q == ST_APP_CMD) || (state_q == ST_CPU_CMD);
  assign in_wr2     = (state_q == ST_APP_WR2) || (state_q == ST_CPU_WR2);
  assign sel_cmd    = sel_is_cpu ? cpu_cmd : app_cmd;
  assign sel_en     = sel_is_cpu ? cpu_cmd_en : app_cmd_en;
  assign starved    = (starve_q == SW'(STARVE_LIMIT));

  // A full tag FIFO holds back reads only; writes never need a tag
  always_comb begin
    dram_cmd_en  = 1'b0;
    dram_cmd_rnw = 1'b0;
    dram_address = '0;
    dram_wr_data = '0;
    dram_wr_be   = '0;
    if (in_cmd || in_wr2) begin
      dram_cmd_rnw = sel_cmd.rnw;
      dram_address = sel_cmd.addr;
      dram_wr_data = sel_cmd.wr_data;
      dram_wr_be   = sel_cmd.wr_be;
    end
    if (in_cmd) begin
      dram_cmd_en = sel_en && !(sel_cmd.rnw && tag_full);
    end
  end

  assign app_ack = dram_ack && dram_cmd_en && !sel_is_cpu;
  assign cpu_ack = dram_ack && dram_cmd_en && sel_is_cpu;
  assign tag_in  = sel_is_cpu ? TAG_CPU : TAG_APP;

  always_comb begin
    state_d  = state_q;
    starve_d = cpu_cmd_en ? starve_q : '0;
    tag_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_cmd_en && (!app_cmd_en || starved)) begin
          state_d  = ST_CPU_CMD;
          starve_d = '0;
        end else if (app_cmd_en) begin
          state_d = ST_APP_CMD;
          if (cpu_cmd_en && !starved) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      ST_APP_CMD, ST_CPU_CMD: begin
        if (dram_cmd_en && dram_ack) begin
          if (sel_cmd.rnw) begin
            tag_push = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = sel_is_cpu ? ST_CPU_WR2 : ST_APP_WR2;
          end
        end else if (!sel_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Each read returns two beats; the tag is retired on the second
  assign rd_route    = dram_rd_dvld && !tag_empty;
  assign tag_pop     = rd_route && beat_q;
  assign beat_d      = beat_q ^ rd_route;
  assign orphan_d    = orphan_q | (dram_rd_dvld && tag_empty);
  assign app_rd_dvld = rd_route && (tag_head == TAG_APP);
  assign cpu_rd_dvld = rd_route && (tag_head == TAG_CPU);
  assign app_rd_data = dram_rd_data;
  assign cpu_rd_data = dram_rd_data;
  assign rd_orphan   = orphan_q;

  always_ff @(posedge dram_clk or posedge dram_rst) begin
    if (dram_rst) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      beat_q   <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      orphan_q <= orphan_d;
    end
  end

  dram_sniffer_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk  (dram_clk),
    .rst  (dram_rst),
    .push (tag_push),
    .pop  (tag_pop),
    .din  (tag_in),
    .dout (tag_head),
    .full (tag_full),
    .empty(tag_empty)
  );

`ifdef DRAM_SNIFFER_ARB_STATS_EN
  always_ff @(posedge dram_clk or posedge dram_rst) begin
    if (dram_rst) begin
      stat_app_cmds     <= '0;
      stat_cpu_cmds     <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (app_ack) begin
        stat_app_cmds <= stat_app_cmds + 32'd1;
      end
      if (cpu_ack) begin
        stat_cpu_cmds <= stat_cpu_cmds + 32'd1;
      end
      if (dram_cmd_en && !dram_ack) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dram_sniffer_arb.sv
// tb/tb_dram_sniffer_arb.sv - vector table, corner sequences and randomized scoreboard for dram_sniffer_arb
module tb_dram_sniffer_arb;

  localparam int TAG_DEPTH    = 8;
  localparam int STARVE_LIMIT = 4;

  logic         dram_clk = 1'b0;
  logic         dram_rst = 1'b1;
  logic         app_cmd_en, app_cmd_rnw, cpu_cmd_en, cpu_cmd_rnw;
  logic [31:0]  app_address, cpu_address;
  logic [143:0] app_wr_data, cpu_wr_data;
  logic [17:0]  app_wr_be, cpu_wr_be;
  logic         app_ack, cpu_ack, app_rd_dvld, cpu_rd_dvld;
  logic [143:0] app_rd_data, cpu_rd_data;
  logic         dram_cmd_en, dram_cmd_rnw;
  logic [31:0]  dram_address;
  logic [143:0] dram_wr_data;
  logic [17:0]  dram_wr_be;
  logic         dram_ack, dram_rd_dvld;
  logic [143:0] dram_rd_data;
  logic         rd_orphan;
`ifdef DRAM_SNIFFER_ARB_STATS_EN
  logic [31:0]  stat_app_cmds, stat_cpu_cmds, stat_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 dram_clk = ~dram_clk;

  dram_sniffer_arb #(
    .TAG_DEPTH   (TAG_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .dram_clk(dram_clk), .dram_rst(dram_rst),
    .app_cmd_en(app_cmd_en), .app_cmd_rnw(app_cmd_rnw), .app_address(app_address),
    .app_wr_data(app_wr_data), .app_wr_be(app_wr_be), .app_ack(app_ack),
    .app_rd_data(app_rd_data), .app_rd_dvld(app_rd_dvld),
    .cpu_cmd_en(cpu_cmd_en), .cpu_cmd_rnw(cpu_cmd_rnw), .cpu_address(cpu_address),
    .cpu_wr_data(cpu_wr_data), .cpu_wr_be(cpu_wr_be), .cpu_ack(cpu_ack),
    .cpu_rd_data(cpu_rd_data), .cpu_rd_dvld(cpu_rd_dvld),
    .dram_cmd_en(dram_cmd_en), .dram_cmd_rnw(dram_cmd_rnw), .dram_address(dram_address),
    .dram_wr_data(dram_wr_data), .dram_wr_be(dram_wr_be), .dram_ack(dram_ack),
    .dram_rd_data(dram_rd_data), .dram_rd_dvld(dram_rd_dvld),
    .rd_orphan(rd_orphan)
`ifdef DRAM_SNIFFER_ARB_STATS_EN
    , .stat_app_cmds(stat_app_cmds), .stat_cpu_cmds(stat_cpu_cmds),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    app_cmd_en = 0; app_cmd_rnw = 0; app_address = 32'h40; app_wr_data = '0; app_wr_be = '1;
    cpu_cmd_en = 0; cpu_cmd_rnw = 0; cpu_address = 32'h80; cpu_wr_data = '0; cpu_wr_be = '1;
    dram_ack = 0; dram_rd_dvld = 0; dram_rd_data = '0;
  endtask

  task automatic do_reset();
    dram_rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge dram_clk);
    #1 dram_rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge dram_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd"}, {dram_cmd_en, dram_cmd_rnw, dram_address, dram_wr_be}, '0);
    check({tag, "_wdata"}, dram_wr_data, '0);
    check({tag, "_acks"}, {app_ack, cpu_ack, app_rd_dvld, cpu_rd_dvld, rd_orphan}, '0);
  endtask

  typedef struct packed {
    logic       app_en, app_rnw, cpu_en, cpu_rnw, ack, dvld;
    logic [7:0] app_wd;
    logic       chk_wd;
    logic [7:0] exp_wd;
    logic       exp_en, exp_app_ack, exp_cpu_ack, exp_app_dvld, exp_cpu_dvld, exp_orphan;
  } vec_t;

  function automatic vec_t mk(input logic ae, ar, ce, cr, ak, dv, input logic [7:0] awd,
                              input logic cw, input logic [7:0] ewd,
                              input logic en, aa, ca, ad, cd, orph);
    vec_t v;
    v = {ae, ar, ce, cr, ak, dv, awd, cw, ewd, en, aa, ca, ad, cd, orph};
    return v;
  endfunction

  vec_t vt[17];

  initial begin
    logic [143:0] rdd;
    int n_app, n_cpu, n_dv;
    logic got;
    int tagq[$];
    int beat, starve_run, wr2_from, acks, app_last, cpu_last;
    logic app_req, cpu_req;

    // ---- vector table: app write then app/cpu read routing then orphan ----
    vt[0]  = mk(1,0,0,0,0,0, 8'h11, 0,8'h00, 0,0,0,0,0,0);
    vt[1]  = mk(1,0,0,0,0,0, 8'h11, 1,8'h11, 1,0,0,0,0,0);
    vt[2]  = mk(1,0,0,0,1,0, 8'h11, 1,8'h11, 1,1,0,0,0,0);
    vt[3]  = mk(0,0,0,0,0,0, 8'h22, 1,8'h22, 0,0,0,0,0,0);
    vt[4]  = mk(0,0,0,0,0,0, 8'h00, 0,8'h00, 0,0,0,0,0,0);
    vt[5]  = mk(1,1,0,0,0,0, 8'h00, 0,8'h00, 0,0,0,0,0,0);
    vt[6]  = mk(1,1,0,0,1,0, 8'h00, 0,8'h00, 1,1,0,0,0,0);
    vt[7]  = mk(0,0,1,1,0,0, 8'h00, 0,8'h00, 0,0,0,0,0,0);
    vt[8]  = mk(0,0,1,1,1,0, 8'h00, 0,8'h00, 1,0,1,0,0,0);
    vt[9]  = mk(0,0,0,0,0,1, 8'h00, 0,8'h00, 0,0,0,1,0,0);
    vt[10] = mk(0,0,0,0,0,1, 8'h00, 0,8'h00, 0,0,0,1,0,0);
    vt[11] = mk(0,0,0,0,0,1, 8'h00, 0,8'h00, 0,0,0,0,1,0);
    vt[12] = mk(0,0,0,0,0,1, 8'h00, 0,8'h00, 0,0,0,0,1,0);
    vt[13] = mk(0,0,0,0,0,0, 8'h00, 0,8'h00, 0,0,0,0,0,0);
    vt[14] = mk(0,0,0,0,0,1, 8'h00, 0,8'h00, 0,0,0,0,0,0);
    vt[15] = mk(0,0,0,0,0,0, 8'h00, 0,8'h00, 0,0,0,0,0,1);
    vt[16] = mk(0,0,0,0,0,0, 8'h00, 0,8'h00, 0,0,0,0,0,1);

    idle_inputs();
    @(negedge dram_clk);
    check_all_zero("reset");
    do_reset();

    for (int i = 0; i < 17; i++) begin
      app_cmd_en = vt[i].app_en; app_cmd_rnw = vt[i].app_rnw;
      cpu_cmd_en = vt[i].cpu_en; cpu_cmd_rnw = vt[i].cpu_rnw;
      app_wr_data = {18{vt[i].app_wd}}; cpu_wr_data = {18{8'h33}};
      dram_ack = vt[i].ack; dram_rd_dvld = vt[i].dvld;
      rdd = {18{8'(i) ^ 8'h5A}};
      dram_rd_data = rdd;
      @(negedge dram_clk);
      check($sformatf("v%0d_en", i), dram_cmd_en, vt[i].exp_en);
      check($sformatf("v%0d_acks", i), {app_ack, cpu_ack}, {vt[i].exp_app_ack, vt[i].exp_cpu_ack});
      check($sformatf("v%0d_dvld", i), {app_rd_dvld, cpu_rd_dvld}, {vt[i].exp_app_dvld, vt[i].exp_cpu_dvld});
      check($sformatf("v%0d_orphan", i), rd_orphan, vt[i].exp_orphan);
      check($sformatf("v%0d_rdata", i), {app_rd_data, cpu_rd_data}, {rdd, rdd});
      if (vt[i].chk_wd) check($sformatf("v%0d_wdata", i), dram_wr_data, {18{vt[i].exp_wd}});
      if (vt[i].exp_en) check($sformatf("v%0d_addr", i), dram_address, vt[i].cpu_en ? 32'h80 : 32'h40);
      if (!vt[i].exp_en && !vt[i].chk_wd) check($sformatf("v%0d_be0", i), dram_wr_be, 18'h0);
      next_cycle();
    end

    // ---- starvation: CPU wins after exactly STARVE_LIMIT app grants ----
    do_reset();
    app_cmd_en = 1; cpu_cmd_en = 1; dram_ack = 1;
    n_app = 0; got = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge dram_clk);
      if (!got) begin
        if (cpu_ack) got = 1;
        else if (app_ack) n_app++;
      end
      next_cycle();
    end
    check("starve_cpu_granted", got, 1'b1);
    check("starve_app_grants", n_app, STARVE_LIMIT);

    // ---- tag full: reads stall, writes pass, drain routes all beats ----
    do_reset();
    app_cmd_en = 1; app_cmd_rnw = 1; dram_ack = 1;
    n_app = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge dram_clk);
      if (app_ack) n_app++;
      next_cycle();
    end
    check("full_reads_accepted", n_app, TAG_DEPTH);
    @(negedge dram_clk);
    check("full_read_blocked", {dram_cmd_en, app_ack}, 2'b00);
    next_cycle();
    app_cmd_rnw = 0;
    @(negedge dram_clk);
    check("full_write_passes", {dram_cmd_en, app_ack}, 2'b11);
    next_cycle();
    app_cmd_en = 0; dram_ack = 0; dram_rd_dvld = 1;
    n_dv = 0; n_cpu = 0;
    for (int c = 0; c < 2 * TAG_DEPTH; c++) begin
      @(negedge dram_clk);
      if (app_rd_dvld) n_dv++;
      if (cpu_rd_dvld) n_cpu++;
      next_cycle();
    end
    check("drain_app_beats", n_dv, 2 * TAG_DEPTH);
    check("drain_cpu_beats", n_cpu, 0);
    dram_rd_dvld = 0;

    // ---- asynchronous reset during the second write beat ----
    do_reset();
    app_cmd_en = 1; app_cmd_rnw = 0; app_wr_data = {18{8'hAA}}; dram_ack = 1;
    next_cycle();
    @(negedge dram_clk);
    check("rst_seq_ack", app_ack, 1'b1);
    next_cycle();
    @(negedge dram_clk);
    check("rst_seq_wr2", {dram_cmd_en, dram_wr_be}, {1'b0, 18'h3FFFF});
    #1 dram_rst = 1'b1;
    #1 check_all_zero("rst_async");
    next_cycle();
    dram_rst = 1'b0;
    @(negedge dram_clk);
    check("rst_release_idle", dram_cmd_en, 1'b0);
    next_cycle();
    @(negedge dram_clk);
    check("rst_release_grant", dram_cmd_en, 1'b1);
    next_cycle();

    // ---- randomized traffic against a transaction-level scoreboard ----
    do_reset();
    tagq = {}; beat = 0; starve_run = 0; wr2_from = 0; acks = 0;
    app_req = 0; cpu_req = 0; app_last = 0; cpu_last = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!app_req) begin
        app_address = $urandom; app_wr_be = 18'($urandom);
        app_wr_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
        app_cmd_rnw = 1'($urandom);
        if (!app_last && $urandom_range(0, 3) != 0) app_req = 1;
      end
      if (!cpu_req) begin
        cpu_address = $urandom; cpu_wr_be = 18'($urandom);
        cpu_wr_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
        cpu_cmd_rnw = 1'($urandom);
        if (!cpu_last && $urandom_range(0, 2) != 0) cpu_req = 1;
      end
      app_last = 0; cpu_last = 0;
      app_cmd_en = app_req; cpu_cmd_en = cpu_req;
      dram_ack = 1'($urandom);
      dram_rd_dvld = (tagq.size() > 0) && ($urandom_range(0, 2) != 0);
      dram_rd_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge dram_clk);

      check("r_app_dvld", app_rd_dvld, dram_rd_dvld && tagq.size() > 0 && tagq[0] == 0);
      check("r_cpu_dvld", cpu_rd_dvld, dram_rd_dvld && tagq.size() > 0 && tagq[0] == 1);
      check("r_rdata", {app_rd_data, cpu_rd_data}, {dram_rd_data, dram_rd_data});
      check("r_orphan", rd_orphan, 1'b0);
      if (wr2_from == 1) check("r_wr2_app", {dram_cmd_en, dram_wr_be, dram_wr_data}, {1'b0, app_wr_be, app_wr_data});
      if (wr2_from == 2) check("r_wr2_cpu", {dram_cmd_en, dram_wr_be, dram_wr_data}, {1'b0, cpu_wr_be, cpu_wr_data});
      if (dram_cmd_en) begin
        check("r_en_src",
              (app_cmd_en && {dram_cmd_rnw, dram_address, dram_wr_data, dram_wr_be} == {app_cmd_rnw, app_address, app_wr_data, app_wr_be}) ||
              (cpu_cmd_en && {dram_cmd_rnw, dram_address, dram_wr_data, dram_wr_be} == {cpu_cmd_rnw, cpu_address, cpu_wr_data, cpu_wr_be}),
              1'b1);
        if (dram_cmd_rnw) check("r_tag_room", tagq.size() < TAG_DEPTH, 1'b1);
      end
      if (dram_cmd_en && dram_ack) begin
        check("r_one_ack", {app_ack, cpu_ack} == 2'b10 || {app_ack, cpu_ack} == 2'b01, 1'b1);
        if (app_ack) check("r_app_fields", {dram_cmd_rnw, dram_address}, {app_cmd_rnw, app_address});
        if (cpu_ack) check("r_cpu_fields", {dram_cmd_rnw, dram_address}, {cpu_cmd_rnw, cpu_address});
      end else begin
        check("r_no_ack", {app_ack, cpu_ack}, 2'b00);
      end
      if (cpu_cmd_en && app_ack) starve_run++;
      if (!cpu_cmd_en || cpu_ack) starve_run = 0;
      check("r_starve_bound", starve_run <= STARVE_LIMIT + 1, 1'b1);

      if (app_rd_dvld || cpu_rd_dvld) begin
        if (beat == 1) begin
          void'(tagq.pop_front());
          beat = 0;
        end else begin
          beat = 1;
        end
      end
      wr2_from = 0;
      if (app_ack) begin
        acks++;
        if (app_cmd_rnw) tagq.push_back(0); else wr2_from = 1;
        app_req = 0; app_last = 1;
      end
      if (cpu_ack) begin
        acks++;
        if (cpu_cmd_rnw) tagq.push_back(1); else wr2_from = 2;
        cpu_req = 0; cpu_last = 1;
      end
      next_cycle();
    end
    check("r_progress", acks > 300, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_sniffer_arb.md
Name: dram_sniffer_arb

Overview:
- Two-port arbiter between a DRAM controller command port and its two requesters.
- The application port (app_*) has priority; the CPU port (cpu_*) connects to the OPB attach block's dram_* interface.
- Read responses return in issue order, two 144-bit beats per read. A tag FIFO routes each response back to the port that issued it.
- Sits in the dram_clk domain, directly downstream of the OPB attach block and upstream of the DRAM controller.

Parameters:
- TAG_DEPTH, 8: maximum outstanding reads; power of 2, minimum 2.
- STARVE_LIMIT, 4: consecutive app grants allowed while the CPU waits; after that, the CPU is forced a grant.

Ports:
- dram_clk  in  1  sole clock.
- dram_rst  in  1  asynchronous, active-high reset.
- app_cmd_en  in  1  app command request; held until app_ack.
- app_cmd_rnw  in  1  1 = read.
- app_address  in  32  command address.
- app_wr_data  in  144  write beat data.
- app_wr_be  in  18  write beat byte enables.
- app_ack  out  1  command accepted.
- app_rd_data  out  144  read beat.
- app_rd_dvld  out  1  read beat valid for app.
- cpu_cmd_en, cpu_cmd_rnw, cpu_address, cpu_wr_data, cpu_wr_be, cpu_ack, cpu_rd_data, cpu_rd_dvld: same widths and meanings, CPU port.
- dram_cmd_en  out  1  command to controller.
- dram_cmd_rnw  out  1  read/write select to controller.
- dram_address  out  32  address to controller.
- dram_wr_data  out  144  write beat to controller.
- dram_wr_be  out  18  byte enables to controller.
- dram_ack  in  1  controller accepted command.
- dram_rd_data  in  144  read beat from controller.
- dram_rd_dvld  in  1  read beat valid from controller.
- rd_orphan  out  1  sticky: a read beat arrived with no outstanding tag.

Behaviour:
- Reset (async, dram_rst=1):
  - state=IDLE, tag FIFO empty, beat toggle=0, starve counter=0, rd_orphan=0.
  - All outputs 0, except *_rd_data, which is don't-care.
- FSM states: IDLE, APP_CMD, APP_WR2, CPU_CMD, CPU_WR2.
- IDLE grant decision, registered (one cycle from request to forwarding):
  - CPU is selected if cpu_cmd_en and (!app_cmd_en or starve==STARVE_LIMIT).
  - Otherwise app is selected if app_cmd_en.
  - Otherwise stay in IDLE.
  - Starve counter: increments on each app grant made while cpu_cmd_en=1; clears on a CPU grant or when cpu_cmd_en=0; saturates at STARVE_LIMIT.
- X_CMD state (X = granted port):
  - dram_cmd_en = X_cmd_en && !(X_cmd_rnw && tag_full).
  - dram_cmd_rnw, dram_address, dram_wr_data, dram_wr_be are forwarded combinationally from X.
  - X_ack = dram_ack && dram_cmd_en. The other port's ack is 0.
  - On ack with read: push tag X, go to IDLE.
  - On ack with write: go to X_WR2.
  - If X drops cmd_en before ack: go to IDLE, no push.
- X_WR2 state (exactly one cycle):
  - Forwards X_wr_data and X_wr_be as the second write beat, with dram_cmd_en=0.
  - Then go to IDLE.
- Outside X_CMD and X_WR2: dram_cmd_en=0, dram_wr_be=0; other dram_* command outputs are don't-care.
- Read return path:
  - dram_rd_data is broadcast unregistered to both *_rd_data.
  - X_rd_dvld = dram_rd_dvld && !empty && head==X.
  - Beat toggle flips on each routed beat; the tag is popped on the second beat.
  - dvld with FIFO empty: no routing, rd_orphan set until reset.
- Simultaneous push and pop: both take effect, so occupancy is unchanged. A push into a full FIFO is impossible by construction.
- A full tag FIFO blocks reads only. Writes still pass.

Optional Feature:
- Macro DRAM_SNIFFER_ARB_STATS_EN.
- When defined, adds outputs:
  - stat_app_cmds, 32-bit: app command count.
  - stat_cpu_cmds, 32-bit: CPU command count.
  - stat_stall_cycles, 32-bit: cycles with dram_cmd_en=1 and dram_ack=0.
  - All counters wrap, are cleared by reset, and increment on ack or stall.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package dram_sniffer_pkg:
  - state encoding.
  - tag encoding: TAG_APP=0, TAG_CPU=1.
  - widths: DATA_W=144, BE_W=18, ADDR_W=32.
- One sub-module, dram_sniffer_tag_fifo: 1-bit wide, depth TAG_DEPTH, with full/empty flags and same-cycle push/pop.

Test Plan:
- App write to 0x40 with ack on the 2nd cycle:
  - app_ack pulses once.
  - Next cycle, dram_wr_data equals app beat 2 and dram_cmd_en=0.
  - cpu_ack stays 0 throughout.
- App read, then CPU read, controller returns 4 dvld beats:
  - Beats 1-2 appear on app_rd_dvld only.
  - Beats 3-4 appear on cpu_rd_dvld only.
  - FIFO ends empty.
- app_cmd_en continuous and cpu_cmd_en held, STARVE_LIMIT=4: CPU granted after exactly 4 app grants.
- 8 app reads issued with no dvld returned: the 9th read sees dram_cmd_en=0 and no ack; an app write is still accepted.
- dram_rd_dvld pulse with FIFO empty: no *_rd_dvld, rd_orphan=1 and held.
- dram_rst asserted mid-X_WR2: all outputs go to 0 immediately (async); state=IDLE on release.
